adder_2_serial: RTL

//  Sequencer that computes WIDTH-bit add/subtract by streaming 2-bit operand slices, LSB first,

---
 rtl/adder_2_serial_pkg.sv | 14 +
 rtl/adder_2_serial_adder_2.sv | 20 ++
 rtl/adder_2_serial.sv | 97 +++++++++
 3 files changed

// File: rtl/adder_2_serial_pkg.sv
// Shared constants for the 2-bit-slice serial adder sequencers.
// State encodings and operation codes are common to every sequencer in this family.
package adder_2_serial_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/adder_2_serial_adder_2.sv
// Combinational 2-bit ripple adder slice: {Cout,S1,S0} = {A1,A0} + {B1,B0} + Cin.
module adder_2 (
    input  logic A0,
    input  logic B0,
    input  logic A1,
    input  logic B1,
    input  logic Cin,
    output logic S0,
    output logic S1,
    output logic Cout
);

    logic c1;

    assign S0   = A0 ^ B0 ^ Cin;
    assign c1   = (A0 & B0) | (Cin & (A0 ^ B0));
    assign S1   = A1 ^ B1 ^ c1;
    assign Cout = (A1 & B1) | (c1 & (A1 ^ B1));

endmodule

// File: rtl/adder_2_serial.sv
// Serial WIDTH-bit add/subtract: streams 2-bit slices LSB first through one adder_2,
// registering the carry between slices and assembling the result in a shift register.
module adder_2_serial
    import adder_2_serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    localparam int SLICES = WIDTH / 2;
    localparam int CW     = $clog2(SLICES) + 1;
    localparam logic [CW-1:0] LAST = CW'(SLICES - 1);

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [WIDTH-3:0] partial;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;

    logic             s0;
    logic             s1;
    logic             s_cout;
    logic [WIDTH-1:0] partial_next;

    adder_2 u_slice (
        .A0   (op_a[0]),
        .B0   (op_b[0]),
        .A1   (op_a[1]),
        .B1   (op_b[1]),
        .Cin  (carry),
        .S0   (s0),
        .S1   (s1),
        .Cout (s_cout)
    );

    // Newest slice enters at the top; on the last slice this is the full result.
    assign partial_next = {s1, s0, partial};

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= ST_IDLE;
            op_a    <= '0;
            op_b    <= '0;
            carry   <= 1'b0;
            partial <= '0;
            cnt     <= '0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    carry   <= s_cout;
                    partial <= partial_next[WIDTH-1:2];
                    op_a    <= op_a >> 2;
                    op_b    <= op_b >> 2;
                    cnt     <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        sum_r  <= partial_next;
                        cout_r <= s_cout;
                        state  <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Accept from IDLE or DONE; subtract becomes A + ~B + 1.
            if (state != ST_RUN && Start) begin
                op_a    <= A;
                op_b    <= B ^ {WIDTH{Op}};
                carry   <= (Op == OP_SUB) ? 1'b1 : Cin;
                partial <= '0;
                cnt     <= '0;
                state   <= ST_RUN;
            end
        end
    end

    assign Busy = (state == ST_RUN);
    assign Done = (state == ST_DONE);
    assign Sum  = sum_r;
    assign Cout = cout_r;

endmodule
